sd_host_registers: RTL and testbench
====================================

Name: sd_host_registers

Overview:
- Memory-mapped register file for an SD host controller. It sits between the host bus (address, write/read enables, 128-bit data) and the command/data engines.
- Holds the transfer configuration and command registers and drives them out as static outputs to the engines.
- Captures the card response on command completion, tracks the command-inhibit state, and accumulates sticky normal/error interrupt status.

Parameters:
- none (widths fixed by the register map)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- adr_i  in  5  register index (map below)
- reg_write_en  in  1  write strobe; data_i written to adr_i on this edge
- reg_read_en  in  1  read strobe; register at adr_i loaded into data_o on this edge
- command_complete  in  1  one-cycle pulse from command engine
- data_i  in  128  write data, LSB-aligned
- response_i  in  128  card response, valid when command_complete=1
- error_interrupt_status_i  in  16  error event bits, OR-ed into sticky status
- normal_interrupt_status_i  in  16  normal event bits, OR-ed into sticky status
- block_size  out  12  BLOCK_SIZE register
- block_count  out  16  BLOCK_COUNT register
- argument  out  32  ARGUMENT register
- transfer_mode  out  16  TRANSFER_MODE register
- command  out  16  COMMAND register
- present_state  out  16  PRESENT_STATE register
- timeout_control  out  16  TIMEOUT_CONTROL register
- software_reset  out  3  SOFTWARE_RESET register (self-clearing)
- error_interrupt_status_o  out  16  sticky error status register
- data_o  out  128  registered read data

Behaviour:
- Register map by adr_i (RW = writable from data_i LSBs):
  - 0 BLOCK_SIZE RW [11:0]
  - 1 BLOCK_COUNT RW [15:0]
  - 2 ARGUMENT RW [31:0]
  - 3 TRANSFER_MODE RW [15:0]
  - 4 COMMAND RW [15:0]
  - 5 RESPONSE RO [127:0]
  - 6 PRESENT_STATE RO [15:0]
  - 7 TIMEOUT_CONTROL RW [15:0]
  - 8 SOFTWARE_RESET RW [2:0]
  - 9 NORMAL_INT_STATUS RW1C [15:0]
  - 10 ERROR_INT_STATUS RW1C [15:0]
  - 11-31: read 0, writes ignored.
- Writes to RO registers are ignored. Upper data_i bits beyond register width are ignored.
- Reset (reset=1 at edge): every register and every output = 0, including data_o. Reset overrides all other activity.
- Write: takes effect at the edge where reg_write_en=1; the output reflects the new value from the next cycle (1-cycle latency).
- Read: at the edge where reg_read_en=1, data_o <= register at adr_i, zero-extended to 128 bits. data_o holds its value when reg_read_en=0.
- Simultaneous read and write to the same address: data_o gets the pre-write value.
- RESPONSE: loads response_i on the edge where command_complete=1; otherwise holds.
- PRESENT_STATE:
  - Bit0 (command inhibit) sets on a write to COMMAND and clears on command_complete.
  - If both occur in the same cycle, set wins.
  - Bits [15:1] are always 0.
- NORMAL_INT_STATUS, each edge: next = (cur & ~clr) | normal_interrupt_status_i | {15'b0, command_complete}.
  - clr = data_i[15:0] when writing adr 9, else 0.
  - A new event in the same cycle as its clear wins (bit stays 1).
- ERROR_INT_STATUS: same rule with error_interrupt_status_i (no command_complete term), clear via adr 10. Drives error_interrupt_status_o.
- SOFTWARE_RESET is self-clearing:
  - A written value is held for exactly one cycle, then returns to 0.
  - While software_reset[0]=1: at that edge every register except SOFTWARE_RESET returns to 0. data_o is unaffected.
  - While software_reset[1]=1: RESPONSE and PRESENT_STATE[0] clear at that edge.
  - software_reset[2] has no internal effect; it is exported for the data engine.
  - A bus write in the same cycle as an active reset bit is discarded for the affected registers.

Test Plan:
- Reset: assert reset 2 cycles -> all outputs 0, data_o=0.
- Write/readback: write adr 0 data 0xFFFF_0A00, adr 2 data 0x1234_5678 -> block_size=0xA00, argument=0x12345678; read adr 2 -> data_o=0x...12345678 next cycle with upper bits 0; read adr 20 -> data_o=0.
- Command flow: write adr 4 data 0x0D1A -> command=0x0D1A, present_state=0x0001. Pulse command_complete with response_i=0xCAFE -> present_state=0, read adr 5 returns 0xCAFE, NORMAL_INT_STATUS bit0=1.
- Interrupt W1C: pulse error_interrupt_status_i=0x0011 -> error_interrupt_status_o=0x0011. Write adr 10 data 0x0001 -> 0x0010. Clear bit4 while error input bit4=1 -> bit4 stays 1.
- Software reset: set block_count=5, timeout_control=0xE. Write adr 8 data 1 -> software_reset=1 for one cycle, then all registers 0 and software_reset=0.
- Read/write collision: block_count=3, same-cycle write 7 and read adr 1 -> data_o=3, block_count=7.

Source files
------------

// File: rtl/sd_host_registers.sv
// SD host controller register file.
// Holds the transfer/command configuration seen by the command and data
// engines, captures the card response, tracks command inhibit and keeps
// sticky normal/error interrupt status with write-one-to-clear semantics.
module sd_host_registers (
   input  logic         clock,
   input  logic         reset,
   input  logic [4:0]   adr_i,
   input  logic         reg_write_en,
   input  logic         reg_read_en,
   input  logic         command_complete,
   input  logic [127:0] data_i,
   input  logic [127:0] response_i,
   input  logic [15:0]  error_interrupt_status_i,
   input  logic [15:0]  normal_interrupt_status_i,
   output logic [11:0]  block_size,
   output logic [15:0]  block_count,
   output logic [31:0]  argument,
   output logic [15:0]  transfer_mode,
   output logic [15:0]  command,
   output logic [15:0]  present_state,
   output logic [15:0]  timeout_control,
   output logic [2:0]   software_reset,
   output logic [15:0]  error_interrupt_status_o,
   output logic [127:0] data_o
);

   localparam logic [4:0] ADR_BLOCK_SIZE      = 5'd0;
   localparam logic [4:0] ADR_BLOCK_COUNT     = 5'd1;
   localparam logic [4:0] ADR_ARGUMENT        = 5'd2;
   localparam logic [4:0] ADR_TRANSFER_MODE   = 5'd3;
   localparam logic [4:0] ADR_COMMAND         = 5'd4;
   localparam logic [4:0] ADR_RESPONSE        = 5'd5;
   localparam logic [4:0] ADR_PRESENT_STATE   = 5'd6;
   localparam logic [4:0] ADR_TIMEOUT_CONTROL = 5'd7;
   localparam logic [4:0] ADR_SOFTWARE_RESET  = 5'd8;
   localparam logic [4:0] ADR_NORMAL_INT      = 5'd9;
   localparam logic [4:0] ADR_ERROR_INT       = 5'd10;

   logic [11:0]  block_size_r;
   logic [15:0]  block_count_r;
   logic [31:0]  argument_r;
   logic [15:0]  transfer_mode_r;
   logic [15:0]  command_r;
   logic [127:0] response_r;
   logic         inhibit_r;
   logic [15:0]  timeout_control_r;
   logic [2:0]   software_reset_r;
   logic [15:0]  normal_int_r;
   logic [15:0]  error_int_r;
   logic [127:0] data_o_r;

   logic [31:0]  wr_en_s;
   logic         sr_all_s;
   logic         sr_cmd_s;
   logic [15:0]  normal_clr_s;
   logic [15:0]  error_clr_s;
   logic [15:0]  normal_next_s;
   logic [15:0]  error_next_s;
   logic [127:0] rd_data_s;
   logic         unused_data_bits_s;

   // Data bits above the widest register (ARGUMENT) never reach any register.
   assign unused_data_bits_s = ^data_i[127:32];

   // Software reset bit 0 clears the whole file; bit 1 clears only the command path.
   assign sr_all_s = software_reset_r[0];
   assign sr_cmd_s = software_reset_r[0] | software_reset_r[1];

   // One-hot write strobe per register index.
   always_comb begin
      wr_en_s = 32'd0;
      if (reg_write_en) begin
         wr_en_s[adr_i] = 1'b1;
      end else begin
         wr_en_s = 32'd0;
      end
   end

   // Sticky interrupt next-state: a new event in the clearing cycle keeps its bit set.
   always_comb begin
      normal_clr_s = 16'd0;
      error_clr_s  = 16'd0;
      if (wr_en_s[ADR_NORMAL_INT]) begin
         normal_clr_s = data_i[15:0];
      end else begin
         normal_clr_s = 16'd0;
      end
      if (wr_en_s[ADR_ERROR_INT]) begin
         error_clr_s = data_i[15:0];
      end else begin
         error_clr_s = 16'd0;
      end
      normal_next_s = (normal_int_r & ~normal_clr_s) | normal_interrupt_status_i
                      | {15'd0, command_complete};
      error_next_s  = (error_int_r & ~error_clr_s) | error_interrupt_status_i;
   end

   // Read mux: current (pre-write) register contents, zero-extended.
   always_comb begin
      rd_data_s = 128'd0;
      case (adr_i)
         ADR_BLOCK_SIZE:      rd_data_s = {116'd0, block_size_r};
         ADR_BLOCK_COUNT:     rd_data_s = {112'd0, block_count_r};
         ADR_ARGUMENT:        rd_data_s = {96'd0, argument_r};
         ADR_TRANSFER_MODE:   rd_data_s = {112'd0, transfer_mode_r};
         ADR_COMMAND:         rd_data_s = {112'd0, command_r};
         ADR_RESPONSE:        rd_data_s = response_r;
         ADR_PRESENT_STATE:   rd_data_s = {127'd0, inhibit_r};
         ADR_TIMEOUT_CONTROL: rd_data_s = {112'd0, timeout_control_r};
         ADR_SOFTWARE_RESET:  rd_data_s = {125'd0, software_reset_r};
         ADR_NORMAL_INT:      rd_data_s = {112'd0, normal_int_r};
         ADR_ERROR_INT:       rd_data_s = {112'd0, error_int_r};
         default:             rd_data_s = 128'd0;
      endcase
   end

   // Host-writable configuration registers; a full software reset discards same-cycle writes.
   always_ff @(posedge clock) begin
      if (reset || sr_all_s) begin
         block_size_r      <= 12'd0;
         block_count_r     <= 16'd0;
         argument_r        <= 32'd0;
         transfer_mode_r   <= 16'd0;
         command_r         <= 16'd0;
         timeout_control_r <= 16'd0;
      end else begin
         if (wr_en_s[ADR_BLOCK_SIZE])      block_size_r      <= data_i[11:0];
         if (wr_en_s[ADR_BLOCK_COUNT])     block_count_r     <= data_i[15:0];
         if (wr_en_s[ADR_ARGUMENT])        argument_r        <= data_i[31:0];
         if (wr_en_s[ADR_TRANSFER_MODE])   transfer_mode_r   <= data_i[15:0];
         if (wr_en_s[ADR_COMMAND])         command_r         <= data_i[15:0];
         if (wr_en_s[ADR_TIMEOUT_CONTROL]) timeout_control_r <= data_i[15:0];
      end
   end

   // Response capture and command inhibit; issuing a command beats a same-cycle completion.
   always_ff @(posedge clock) begin
      if (reset || sr_cmd_s) begin
         response_r <= 128'd0;
         inhibit_r  <= 1'b0;
      end else begin
         if (command_complete) begin
            response_r <= response_i;
         end else begin
            response_r <= response_r;
         end
         if (wr_en_s[ADR_COMMAND]) begin
            inhibit_r <= 1'b1;
         end else if (command_complete) begin
            inhibit_r <= 1'b0;
         end else begin
            inhibit_r <= inhibit_r;
         end
      end
   end

   // Sticky interrupt status registers.
   always_ff @(posedge clock) begin
      if (reset || sr_all_s) begin
         normal_int_r <= 16'd0;
         error_int_r  <= 16'd0;
      end else begin
         normal_int_r <= normal_next_s;
         error_int_r  <= error_next_s;
      end
   end

   // Self-clearing software reset: a written value lives for exactly one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         software_reset_r <= 3'd0;
      end else if (wr_en_s[ADR_SOFTWARE_RESET]) begin
         software_reset_r <= data_i[2:0];
      end else begin
         software_reset_r <= 3'd0;
      end
   end

   // Registered read data; holds between read strobes and ignores software reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         data_o_r <= 128'd0;
      end else if (reg_read_en) begin
         data_o_r <= rd_data_s;
      end else begin
         data_o_r <= data_o_r;
      end
   end

   assign block_size               = block_size_r;
   assign block_count              = block_count_r;
   assign argument                 = argument_r;
   assign transfer_mode            = transfer_mode_r;
   assign command                  = command_r;
   assign present_state            = {15'd0, inhibit_r};
   assign timeout_control          = timeout_control_r;
   assign software_reset           = software_reset_r;
   assign error_interrupt_status_o = error_int_r;
   assign data_o                   = data_o_r;

endmodule

// File: tb/tb_sd_host_registers.sv
// Directed self-checking bench for sd_host_registers.
module tb_sd_host_registers;

   logic         clock = 1'b0;
   logic         reset;
   logic [4:0]   adr_i;
   logic         reg_write_en;
   logic         reg_read_en;
   logic         command_complete;
   logic [127:0] data_i;
   logic [127:0] response_i;
   logic [15:0]  error_interrupt_status_i;
   logic [15:0]  normal_interrupt_status_i;
   logic [11:0]  block_size;
   logic [15:0]  block_count;
   logic [31:0]  argument;
   logic [15:0]  transfer_mode;
   logic [15:0]  command;
   logic [15:0]  present_state;
   logic [15:0]  timeout_control;
   logic [2:0]   software_reset;
   logic [15:0]  error_interrupt_status_o;
   logic [127:0] data_o;

   int checks = 0;
   int errors = 0;

   sd_host_registers dut (
      .clock                     (clock),
      .reset                     (reset),
      .adr_i                     (adr_i),
      .reg_write_en              (reg_write_en),
      .reg_read_en               (reg_read_en),
      .command_complete          (command_complete),
      .data_i                    (data_i),
      .response_i                (response_i),
      .error_interrupt_status_i  (error_interrupt_status_i),
      .normal_interrupt_status_i (normal_interrupt_status_i),
      .block_size                (block_size),
      .block_count               (block_count),
      .argument                  (argument),
      .transfer_mode             (transfer_mode),
      .command                   (command),
      .present_state             (present_state),
      .timeout_control           (timeout_control),
      .software_reset            (software_reset),
      .error_interrupt_status_o  (error_interrupt_status_o),
      .data_o                    (data_o)
   );

   always #5 clock = ~clock;

   // Advance one rising edge and settle past it before inputs change or outputs are sampled.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic wr(input logic [4:0] adr, input logic [127:0] dat);
      reg_write_en = 1'b1;
      adr_i        = adr;
      data_i       = dat;
      step();
      reg_write_en = 1'b0;
      data_i       = 128'd0;
   endtask

   task automatic rd(input logic [4:0] adr);
      reg_read_en = 1'b1;
      adr_i       = adr;
      step();
      reg_read_en = 1'b0;
   endtask

   initial begin
      reset                     = 1'b1;
      adr_i                     = 5'd0;
      reg_write_en              = 1'b0;
      reg_read_en               = 1'b0;
      command_complete          = 1'b0;
      data_i                    = 128'd0;
      response_i                = 128'd0;
      error_interrupt_status_i  = 16'd0;
      normal_interrupt_status_i = 16'd0;

      // Reset
      step();
      step();
      check("rst_block_size", {116'd0, block_size}, 128'd0);
      check("rst_block_count", {112'd0, block_count}, 128'd0);
      check("rst_argument", {96'd0, argument}, 128'd0);
      check("rst_transfer_mode", {112'd0, transfer_mode}, 128'd0);
      check("rst_command", {112'd0, command}, 128'd0);
      check("rst_present_state", {112'd0, present_state}, 128'd0);
      check("rst_timeout", {112'd0, timeout_control}, 128'd0);
      check("rst_sw_reset", {125'd0, software_reset}, 128'd0);
      check("rst_err_int", {112'd0, error_interrupt_status_o}, 128'd0);
      check("rst_data_o", data_o, 128'd0);
      reset = 1'b0;

      // Write / readback, upper data bits ignored
      wr(5'd0, 128'hFFFF_0A00);
      check("block_size_wr", {116'd0, block_size}, 128'h0A00);
      wr(5'd2, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h1234_5678});
      check("argument_wr", {96'd0, argument}, 128'h1234_5678);
      rd(5'd2);
      check("rd_argument", data_o, 128'h1234_5678);
      rd(5'd20);
      check("rd_unmapped", data_o, 128'd0);

      // Command flow
      wr(5'd4, 128'h0D1A);
      check("command_wr", {112'd0, command}, 128'h0D1A);
      check("inhibit_set", {112'd0, present_state}, 128'h0001);
      command_complete = 1'b1;
      response_i       = 128'hCAFE;
      step();
      command_complete = 1'b0;
      check("inhibit_clr", {112'd0, present_state}, 128'd0);
      rd(5'd5);
      check("rd_response", data_o, 128'hCAFE);
      rd(5'd9);
      check("rd_normal_int", data_o, 128'h0001);
      wr(5'd9, 128'h0001);
      rd(5'd9);
      check("normal_w1c", data_o, 128'd0);

      // Error interrupt W1C
      error_interrupt_status_i = 16'h0011;
      step();
      error_interrupt_status_i = 16'h0000;
      check("err_sticky", {112'd0, error_interrupt_status_o}, 128'h0011);
      wr(5'd10, 128'h0001);
      check("err_w1c", {112'd0, error_interrupt_status_o}, 128'h0010);
      error_interrupt_status_i = 16'h0010;
      wr(5'd10, 128'h0010);
      error_interrupt_status_i = 16'h0000;
      check("err_set_wins", {112'd0, error_interrupt_status_o}, 128'h0010);
      wr(5'd10, 128'h0010);
      check("err_cleared", {112'd0, error_interrupt_status_o}, 128'd0);

      // Write to read-only PRESENT_STATE ignored
      wr(5'd6, 128'hFFFF);
      check("ro_present_state", {112'd0, present_state}, 128'd0);

      // Full software reset
      wr(5'd1, 128'd5);
      wr(5'd7, 128'h000E);
      rd(5'd7);
      check("rd_timeout", data_o, 128'h000E);
      check("block_count_5", {112'd0, block_count}, 128'd5);
      wr(5'd8, 128'd1);
      check("sw_reset_pulse", {125'd0, software_reset}, 128'd1);
      check("pre_srst_count", {112'd0, block_count}, 128'd5);
      step();
      check("sw_reset_selfclr", {125'd0, software_reset}, 128'd0);
      check("srst_block_count", {112'd0, block_count}, 128'd0);
      check("srst_timeout", {112'd0, timeout_control}, 128'd0);
      check("srst_block_size", {116'd0, block_size}, 128'd0);
      check("srst_argument", {96'd0, argument}, 128'd0);
      check("srst_command", {112'd0, command}, 128'd0);
      check("srst_data_o_kept", data_o, 128'h000E);

      // Command-path software reset
      command_complete = 1'b1;
      response_i       = 128'hBEEF;
      step();
      command_complete = 1'b0;
      wr(5'd4, 128'h0005);
      check("inhibit_again", {112'd0, present_state}, 128'h0001);
      wr(5'd8, 128'd2);
      check("sw_reset_cmd", {125'd0, software_reset}, 128'd2);
      step();
      check("srst1_inhibit", {112'd0, present_state}, 128'd0);
      check("srst1_command_kept", {112'd0, command}, 128'h0005);
      rd(5'd5);
      check("srst1_response", data_o, 128'd0);

      // Same-cycle read and write
      wr(5'd1, 128'd3);
      reg_write_en = 1'b1;
      reg_read_en  = 1'b1;
      adr_i        = 5'd1;
      data_i       = 128'd7;
      step();
      reg_write_en = 1'b0;
      reg_read_en  = 1'b0;
      check("collision_data_o", data_o, 128'd3);
      check("collision_count", {112'd0, block_count}, 128'd7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
